// File: rtl/uart_param_core.sv
// uart_param_core: parametrised UART with glitch-filtered RX, show-ahead RX FIFO, ready/valid TX and optional echo
module uart_param_core #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_rxd,
  output logic                              o_txd,
  input  logic                              i_echo_en,
  input  logic [7:0]                        i_tx_data,
  input  logic                              i_tx_valid,
  output logic                              o_tx_ready,
  output logic                              o_tx_done,
  input  logic                              i_rx_rd,
  output logic                              o_rx_valid,
  output logic [7:0]                        o_data_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_rx_count,
  output logic                              o_parity_err,
  output logic                              o_frame_err,
  output logic                              o_overflow
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW = $clog2(DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam logic [7:0] MASK = 8'((16'd1 << DATA_BITS) - 16'd1);
  localparam logic ODD = (PARITY == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  logic r_rx_s1, r_rx_s2, r_rx_prev;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= i_rxd;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end

  state_t          r_rx_state, w_rx_next;
  logic [CW-1:0]   r_rx_cnt;
  logic [2:0]      r_rx_bit;
  logic [7:0]      r_rx_sh, r_rx_byte, w_rx_data;
  logic            r_rx_par, r_rx_wr, r_perr, r_ferr;
  logic            w_rx_fall, w_rx_tick, w_rx_stop, w_rx_par_bad;

  assign w_rx_fall    = r_rx_prev & ~r_rx_s2;
  // START waits half a bit so every later sample lands mid-bit
  assign w_rx_tick    = r_rx_cnt == (r_rx_state == S_START ? CW'(DIV/2 - 1) : CW'(DIV - 1));
  assign w_rx_stop    = r_rx_state == S_STOP && w_rx_tick;
  assign w_rx_data    = r_rx_sh >> (8 - DATA_BITS);
  assign w_rx_par_bad = (PARITY != 0) && (r_rx_par != (^w_rx_data ^ ODD));

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      S_IDLE:  if (w_rx_fall) w_rx_next = S_START;
      S_START: if (w_rx_tick) w_rx_next = r_rx_s2 ? S_IDLE : S_DATA;
      S_DATA:  if (w_rx_tick && r_rx_bit == 3'(DATA_BITS - 1)) w_rx_next = PARITY != 0 ? S_PAR : S_STOP;
      S_PAR:   if (w_rx_tick) w_rx_next = S_STOP;
      S_STOP:  if (w_rx_tick) w_rx_next = S_IDLE;
      default: w_rx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_sh    <= '0;
      r_rx_par   <= 1'b0;
      r_rx_byte  <= '0;
      r_rx_wr    <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_rx_state <= w_rx_next;
      r_rx_cnt   <= (r_rx_state == S_IDLE || w_rx_tick) ? '0 : r_rx_cnt + CW'(1);
      r_rx_bit   <= r_rx_state != S_DATA ? '0 : r_rx_bit + 3'(w_rx_tick);
      if (r_rx_state == S_DATA && w_rx_tick) r_rx_sh <= {r_rx_s2, r_rx_sh[7:1]};
      if (r_rx_state == S_PAR && w_rx_tick) r_rx_par <= r_rx_s2;
      if (w_rx_stop) r_rx_byte <= w_rx_data;
      r_rx_wr    <= w_rx_stop && r_rx_s2 && !w_rx_par_bad;
      r_ferr     <= w_rx_stop && !r_rx_s2;
      r_perr     <= w_rx_stop && w_rx_par_bad;
    end

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [NW-1:0] r_cnt;
  logic [7:0]    r_echo;
  logic          r_echo_v;
  logic          w_full, w_pop, w_push, w_echo_set, w_echo_take;

  assign w_full      = r_cnt == NW'(FIFO_DEPTH);
  assign w_pop       = i_rx_rd && r_cnt != '0;
  assign w_push      = r_rx_wr && (!w_full || w_pop);
  assign w_echo_set  = r_rx_wr && i_echo_en && !r_echo_v;
  assign o_overflow  = r_rx_wr && ((w_full && !w_pop) || (i_echo_en && r_echo_v));
  assign o_rx_valid  = r_cnt != '0;
  assign o_rx_count  = r_cnt;
  assign o_data_out  = r_cnt != '0 ? r_mem[r_rp] : '0;
  assign o_parity_err = r_perr;
  assign o_frame_err  = r_ferr;

  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wp] <= r_rx_byte;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      r_echo   <= '0;
      r_echo_v <= 1'b0;
    end else begin
      r_wp     <= r_wp + AW'(w_push);
      r_rp     <= r_rp + AW'(w_pop);
      r_cnt    <= r_cnt + NW'(w_push) - NW'(w_pop);
      if (w_echo_set) r_echo <= r_rx_byte;
      r_echo_v <= w_echo_set ? 1'b1 : w_echo_take ? 1'b0 : r_echo_v;
    end

  state_t        r_tx_state, w_tx_next;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_sh, w_tx_src;
  logic          r_tx_par, w_tx_tick, w_tx_load;

  assign w_tx_tick   = r_tx_cnt == CW'(DIV - 1);
  assign w_tx_load   = r_tx_state == S_IDLE && (r_echo_v || i_tx_valid);
  assign w_echo_take = r_tx_state == S_IDLE && r_echo_v;
  assign w_tx_src    = (r_echo_v ? r_echo : i_tx_data) & MASK;
  assign o_tx_ready  = r_tx_state == S_IDLE && !r_echo_v;
  assign o_tx_done   = r_tx_state == S_STOP && w_tx_tick && r_tx_bit == 3'(STOP_BITS - 1);
  assign o_txd       = r_tx_state == S_START ? 1'b0 : r_tx_state == S_DATA ? r_tx_sh[0] :
                       r_tx_state == S_PAR ? r_tx_par : 1'b1;

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      S_IDLE:  if (w_tx_load) w_tx_next = S_START;
      S_START: if (w_tx_tick) w_tx_next = S_DATA;
      S_DATA:  if (w_tx_tick && r_tx_bit == 3'(DATA_BITS - 1)) w_tx_next = PARITY != 0 ? S_PAR : S_STOP;
      S_PAR:   if (w_tx_tick) w_tx_next = S_STOP;
      S_STOP:  if (o_tx_done) w_tx_next = S_IDLE;
      default: w_tx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_sh    <= '0;
      r_tx_par   <= 1'b0;
    end else begin
      r_tx_state <= w_tx_next;
      r_tx_cnt   <= (r_tx_state == S_IDLE || w_tx_tick) ? '0 : r_tx_cnt + CW'(1);
      r_tx_bit   <= w_tx_next != r_tx_state ? '0 : r_tx_bit + 3'(w_tx_tick);
      if (w_tx_load) begin
        r_tx_sh  <= w_tx_src;
        r_tx_par <= ^w_tx_src ^ ODD;
      end else if (r_tx_state == S_DATA && w_tx_tick) r_tx_sh <= r_tx_sh >> 1;
    end
endmodule

// File: tb/tb_uart_param_core.sv
// tb_uart_param_core: directed bench for an 8N1 core and an even-parity core, both at DIV=10
module tb_uart_param_core;
  logic clk = 1'b0, rst_n = 1'b0;
  logic rxd = 1'b1, rxd_p = 1'b1, echo_en = 1'b0, tx_valid = 1'b0, rx_rd = 1'b0, rx_rd_p = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic txd, tx_ready, tx_done, rx_valid, perr, ferr, ovf;
  logic [7:0] data_out;
  logic [2:0] rx_count;
  logic p_txd, p_tx_ready, p_tx_done, p_rx_valid, p_perr, p_ferr, p_ovf;
  logic [7:0] p_data_out;
  logic [2:0] p_rx_count;
  int n_cmp = 0, n_bad = 0;
  int ferr_n = 0, ovf_n = 0, p_perr_n = 0, p_ferr_n = 0;

  uart_param_core #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rxd(rxd), .o_txd(txd), .i_echo_en(echo_en),
    .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready), .o_tx_done(tx_done),
    .i_rx_rd(rx_rd), .o_rx_valid(rx_valid), .o_data_out(data_out), .o_rx_count(rx_count),
    .o_parity_err(perr), .o_frame_err(ferr), .o_overflow(ovf));

  uart_param_core #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_par (
    .i_clk(clk), .i_rst_n(rst_n), .i_rxd(rxd_p), .o_txd(p_txd), .i_echo_en(1'b0),
    .i_tx_data(8'h00), .i_tx_valid(1'b0), .o_tx_ready(p_tx_ready), .o_tx_done(p_tx_done),
    .i_rx_rd(rx_rd_p), .o_rx_valid(p_rx_valid), .o_data_out(p_data_out), .o_rx_count(p_rx_count),
    .o_parity_err(p_perr), .o_frame_err(p_ferr), .o_overflow(p_ovf));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ferr_n   += int'(ferr);
    ovf_n    += int'(ovf);
    p_perr_n += int'(p_perr);
    p_ferr_n += int'(p_ferr);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic send(input logic [11:0] bits, input int n, input bit p);
    for (int i = 0; i < n; i++) begin
      if (p) rxd_p = bits[i]; else rxd = bits[i];
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic pop;
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
  endtask

  task automatic tx_capture(output logic [7:0] d, output logic stop, output bit ok);
    ok = 1'b0; d = '0; stop = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (txd === 1'b0) ok = 1'b1; else @(negedge clk);
    end
    if (ok) begin
      repeat (4) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (10) @(negedge clk);
        d[i] = txd;
      end
      repeat (10) @(negedge clk);
      stop = txd;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL reset_txd: got %b want 1", txd); end
    n_cmp++; if (tx_done !== 1'b0) begin n_bad++; $display("FAIL reset_tx_done: got %b want 0", tx_done); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data_out: got %h want 00", data_out); end
    n_cmp++; if (rx_count !== 3'd0) begin n_bad++; $display("FAIL reset_rx_count: got %0d want 0", rx_count); end
    n_cmp++; if ({perr, ferr, ovf} !== 3'b000) begin n_bad++; $display("FAIL reset_errs: got %b want 000", {perr, ferr, ovf}); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
  endtask

  task automatic test_tx;
    logic [9:0] frame;
    frame = {1'b1, 8'hA5, 1'b0};
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int k = 0; k < 100; k++) begin
      n_cmp++; if (txd !== frame[k/10]) begin n_bad++; $display("FAIL tx_bit k=%0d: got %b want %b", k, txd, frame[k/10]); end
      n_cmp++; if (tx_done !== (k == 99)) begin n_bad++; $display("FAIL tx_done k=%0d: got %b want %b", k, tx_done, k == 99); end
      if (k == 50) begin tx_data = 8'hFF; tx_valid = 1'b1; end
      if (k == 60) tx_valid = 1'b0;
      @(negedge clk);
    end
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL tx_ready_after: got %b want 1", tx_ready); end
    for (int k = 0; k < 30; k++) begin
      n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL tx_busy_ignored k=%0d: got %b want 1", k, txd); end
      @(negedge clk);
    end
  endtask

  task automatic test_rx_echo;
    logic [7:0] d;
    logic stop;
    bit ok;
    echo_en = 1'b1;
    send({2'b11, 1'b1, 8'h3C, 1'b0}, 10, 1'b0);
    repeat (2) @(negedge clk);
    n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL echo_rx_valid: got %b want 1", rx_valid); end
    n_cmp++; if (data_out !== 8'h3C) begin n_bad++; $display("FAIL echo_data_out: got %h want 3c", data_out); end
    n_cmp++; if (rx_count !== 3'd1) begin n_bad++; $display("FAIL echo_rx_count: got %0d want 1", rx_count); end
    tx_capture(d, stop, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL echo_tx_start: got no start bit want start bit"); end
    n_cmp++; if (d !== 8'h3C) begin n_bad++; $display("FAIL echo_tx_data: got %h want 3c", d); end
    n_cmp++; if (stop !== 1'b1) begin n_bad++; $display("FAIL echo_tx_stop: got %b want 1", stop); end
    pop();
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL echo_pop_valid: got %b want 0", rx_valid); end
    n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL echo_pop_data: got %h want 00", data_out); end
    echo_en = 1'b0;
    repeat (15) @(negedge clk);
  endtask

  task automatic test_parity;
    int b;
    b = p_perr_n;
    send({1'b1, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 1'b1);
    repeat (2) @(negedge clk);
    n_cmp++; if (p_perr_n - b !== 1) begin n_bad++; $display("FAIL parity_err_pulse: got %0d want 1", p_perr_n - b); end
    n_cmp++; if (p_rx_count !== 3'd0) begin n_bad++; $display("FAIL parity_discard: got %0d want 0", p_rx_count); end
    n_cmp++; if (p_ferr_n !== 0) begin n_bad++; $display("FAIL parity_no_ferr: got %0d want 0", p_ferr_n); end
    send({1'b1, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 1'b1);
    repeat (2) @(negedge clk);
    n_cmp++; if (p_rx_count !== 3'd1) begin n_bad++; $display("FAIL parity_good_count: got %0d want 1", p_rx_count); end
    n_cmp++; if (p_data_out !== 8'h07) begin n_bad++; $display("FAIL parity_good_data: got %h want 07", p_data_out); end
    n_cmp++; if (p_perr_n - b !== 1) begin n_bad++; $display("FAIL parity_good_no_err: got %0d want 1", p_perr_n - b); end
    rx_rd_p = 1'b1;
    @(negedge clk);
    rx_rd_p = 1'b0;
    n_cmp++; if (p_rx_valid !== 1'b0) begin n_bad++; $display("FAIL parity_pop: got %b want 0", p_rx_valid); end
  endtask

  task automatic test_frame_err;
    int b;
    b = ferr_n;
    send({2'b11, 1'b0, 8'h55, 1'b0}, 10, 1'b0);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++; if (ferr_n - b !== 1) begin n_bad++; $display("FAIL frame_err_pulse: got %0d want 1", ferr_n - b); end
    n_cmp++; if (rx_count !== 3'd0) begin n_bad++; $display("FAIL frame_err_discard: got %0d want 0", rx_count); end
    send({2'b11, 1'b1, 8'hAA, 1'b0}, 10, 1'b0);
    repeat (2) @(negedge clk);
    n_cmp++; if (data_out !== 8'hAA) begin n_bad++; $display("FAIL frame_next_data: got %h want aa", data_out); end
    n_cmp++; if (rx_count !== 3'd1) begin n_bad++; $display("FAIL frame_next_count: got %0d want 1", rx_count); end
    n_cmp++; if (ferr_n - b !== 1) begin n_bad++; $display("FAIL frame_next_no_err: got %0d want 1", ferr_n - b); end
    pop();
  endtask

  task automatic test_overflow;
    int b;
    logic [7:0] v;
    b = ovf_n;
    for (int i = 1; i <= 5; i++) begin
      v = 8'(i);
      send({3'b111, v, 1'b0}, 10, 1'b0);
    end
    repeat (2) @(negedge clk);
    n_cmp++; if (ovf_n - b !== 1) begin n_bad++; $display("FAIL ovf_pulse: got %0d want 1", ovf_n - b); end
    n_cmp++; if (rx_count !== 3'd4) begin n_bad++; $display("FAIL ovf_count: got %0d want 4", rx_count); end
    for (int i = 1; i <= 4; i++) begin
      n_cmp++; if (data_out !== 8'(i)) begin n_bad++; $display("FAIL ovf_pop%0d: got %h want %h", i, data_out, 8'(i)); end
      pop();
    end
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_drained: got %b want 0", rx_valid); end
    for (int i = 0; i < 4; i++) begin
      v = 8'h11 + 8'(i);
      send({3'b111, v, 1'b0}, 10, 1'b0);
    end
    b = ovf_n;
    send({3'b111, 8'h15, 1'b0}, 9, 1'b0);
    rxd = 1'b1;
    repeat (8) @(negedge clk);
    pop();
    repeat (3) @(negedge clk);
    n_cmp++; if (ovf_n - b !== 0) begin n_bad++; $display("FAIL full_pushpop_ovf: got %0d want 0", ovf_n - b); end
    n_cmp++; if (rx_count !== 3'd4) begin n_bad++; $display("FAIL full_pushpop_count: got %0d want 4", rx_count); end
    for (int i = 2; i <= 5; i++) begin
      v = 8'h10 + 8'(i);
      n_cmp++; if (data_out !== v) begin n_bad++; $display("FAIL full_pushpop_pop: got %h want %h", data_out, v); end
      pop();
    end
  endtask

  task automatic test_glitch;
    int b;
    b = ferr_n;
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    n_cmp++; if (rx_count !== 3'd0) begin n_bad++; $display("FAIL glitch_count: got %0d want 0", rx_count); end
    n_cmp++; if (ferr_n - b !== 0) begin n_bad++; $display("FAIL glitch_ferr: got %0d want 0", ferr_n - b); end
    send({2'b11, 1'b1, 8'h5A, 1'b0}, 10, 1'b0);
    repeat (2) @(negedge clk);
    n_cmp++; if (data_out !== 8'h5A) begin n_bad++; $display("FAIL glitch_rearm_data: got %h want 5a", data_out); end
    pop();
  endtask

  task automatic test_reset_mid_tx;
    tx_data = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (30) @(negedge clk);
    n_cmp++; if (txd !== 1'b0) begin n_bad++; $display("FAIL midtx_busy_txd: got %b want 0", txd); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL midtx_reset_txd: got %b want 1", txd); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL midtx_tx_ready: got %b want 1", tx_ready); end
    n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL midtx_txd_after: got %b want 1", txd); end
  endtask

  initial begin
    test_reset();
    test_tx();
    test_rx_echo();
    test_parity();
    test_frame_err();
    test_overflow();
    test_glitch();
    test_reset_mid_tx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
